mem_dump_ctrl: RTL

Hardware end-of-run controller for the processor.
- Counts cycles after reset release; on reaching a programmable run time, halts the core.
- Then reads a window of data memory word by word and streams each (address, data) pair out on a valid/ready interface for capture by the host/bench.
- It is the read-out side of the memory image that the load path writes in at start of run.

---
 rtl/mem_dump_ctrl_if.sv | 42 ++++
 rtl/mem_dump_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_ctrl_if
// Brief    : Memory read port and (address, data) stream of the dump controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_dump_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
        input  out_last
    );
endinterface
`default_nettype wire

// File: rtl/mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_dump_ctrl
// Brief    : End-of-run controller: halts the core after a programmed cycle
//            count, then streams a data-memory window out as (addr, data).
// Revision : 1.0 - initial release
// ============================================================================
module mem_dump_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 1024
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        run_en,
    input  wire logic [31:0] run_time,
    output logic             halt,
    output logic             busy,
    output logic             done,
    mem_dump_ctrl_if.master  bus
);
    localparam int                    c_IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BASE     = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HALT = 3'd1;
    localparam logic [2:0] c_ST_READ = 3'd2;
    localparam logic [2:0] c_ST_WAIT = 3'd3;
    localparam logic [2:0] c_ST_SEND = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    logic [2:0]            r_state;
    logic [31:0]           r_cycle_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_addr = c_BASE + ADDR_WIDTH'(r_idx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_cycle_cnt   <= '0;
            r_idx         <= '0;
            halt          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run_en && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
                        r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    end
                    if (r_cycle_cnt >= run_time) begin
                        r_state <= c_ST_HALT;
                        halt    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                // One idle halted cycle lets in-flight core writes retire.
                c_ST_HALT: begin
                    r_state       <= c_ST_READ;
                    r_idx         <= '0;
                    bus.mem_rd_en <= 1'b1;
                    bus.mem_addr  <= c_BASE;
                end
                c_ST_READ: begin
                    bus.mem_rd_en <= 1'b0;
                    r_state       <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    bus.out_data  <= bus.mem_rd_data;
                    bus.out_addr  <= w_addr;
                    bus.out_last  <= (r_idx == c_LAST_IDX);
                    bus.out_valid <= 1'b1;
                    r_state       <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (bus.out_last) begin
                            bus.out_last <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            r_state      <= c_ST_DONE;
                        end else begin
                            r_idx         <= r_idx + c_IDX_W'(1);
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= w_addr + ADDR_WIDTH'(1);
                            r_state       <= c_ST_READ;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
